// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_issue_ctrl_pkg
//   Shared FPU issue definitions: slow-unit op classes, slow FSM states,
//   default unit latencies and the slow-op latency lookup used to load the
//   slow-unit countdown.
package fpu_issue_ctrl_pkg;

  // Slow FPU op class as presented on slow_op / slow_op_out.
  typedef enum logic [1:0] {
    SOP_DIV  = 2'b00,
    SOP_SQRT = 2'b01,
    SOP_FMA  = 2'b10,
    SOP_RSVD = 2'b11   // unused encoding, runs with the FMA latency
  } slow_op_e;

  // Slow FPU occupancy FSM.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } slow_state_e;

  // Default latencies in cycles.
  localparam int unsigned DEF_FAST_LAT = 2;
  localparam int unsigned DEF_DIV_LAT  = 10;
  localparam int unsigned DEF_SQRT_LAT = 12;
  localparam int unsigned DEF_FMA_LAT  = 4;

  // Countdown width; every latency must fit below 2**CNT_W.
  localparam int unsigned CNT_W = 8;

  // Countdown start value (latency - 1) for a slow op class.
  // A zero latency is clamped to one so the counter never underflows.
  function automatic logic [CNT_W-1:0] slow_cnt_init(
    input logic [1:0]  op,
    input int unsigned div_lat,
    input int unsigned sqrt_lat,
    input int unsigned fma_lat
  );
    int unsigned lat;
    case (slow_op_e'(op))
      SOP_DIV:  lat = div_lat;
      SOP_SQRT: lat = sqrt_lat;
      default:  lat = fma_lat;
    endcase
    if (lat == 0) lat = 1;
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_fast_tracker.sv
// fpu_fast_tracker
//   FAST_LAT-deep shift register tracking fast-FPU ops in flight. One entry
//   is shifted in every cycle; an entry with in_vld = 1 marks an op that will
//   write the FPU regfile when it reaches the tail, FAST_LAT cycles later.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   in_vld, in_rd      entry shifted in this cycle (valid + destination)
//   tail_vld, tail_rd  oldest entry, i.e. the fast writeback due this cycle
module fpu_fast_tracker #(
  parameter int unsigned FAST_LAT = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_vld,
  input  logic [4:0] in_rd,
  output logic       tail_vld,
  output logic [4:0] tail_rd
);

  logic [FAST_LAT-1:0] vld_q, vld_d;
  logic [4:0]          rd_q [FAST_LAT];
  logic [4:0]          rd_d [FAST_LAT];

  always_comb begin
    vld_d[0] = in_vld;
    // Non-writing slots carry rd 0 so the tail is clean when invalid.
    rd_d[0]  = in_vld ? in_rd : 5'd0;
    for (int i = 1; i < int'(FAST_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      rd_d[i]  = rd_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int i = 0; i < int'(FAST_LAT); i++) rd_q[i] <= 5'd0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < int'(FAST_LAT); i++) rd_q[i] <= rd_d[i];
    end
  end

  assign tail_vld = vld_q[FAST_LAT-1];
  assign tail_rd  = rd_q[FAST_LAT-1];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Issue control for a fast fixed-latency FPU and a single slow FPU
//   (div/sqrt/fma). Tracks the slow unit with an IDLE/BUSY/WB FSM, tracks
//   fast ops with a shift register, generates decode stall for structural
//   and register hazards, and arbitrates the single FPU regfile write port
//   (fast results always win; the slow result waits in WB).
//
// Decode handshake: id_valid is the valid, ~stall is the ready. An op is
//   accepted in a cycle where id_valid = 1, stall = 0 and flush = 0; while
//   stalled, decode holds the op stable. stall is never raised without
//   id_valid, and flush forces stall low and blocks the accept.
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   id_valid                       decode has an FPU op
//   fast_fpu_dispatch / slow_...   target unit of the op
//   fpu_reg_write                  op writes the FPU regfile
//   slow_op                        slow op class (div/sqrt/fma)
//   rd, rs1, rs2, rs3, rs3_valid   destination and sources
//   flush                          kill the decode op
//   stall                          hold decode
//   slow_start                     one-cycle start pulse to slow unit
//   slow_op_out                    op class latched at slow_start
//   slow_busy                      slow unit occupied (BUSY or WB)
//   wb_en, wb_sel, wb_rd           regfile write: enable, 0 fast/1 slow, addr
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned FAST_LAT = DEF_FAST_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned SQRT_LAT = DEF_SQRT_LAT,
  parameter int unsigned FMA_LAT  = DEF_FMA_LAT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       id_valid,
  input  logic       fast_fpu_dispatch,
  input  logic       slow_fpu_dispatch,
  input  logic       fpu_reg_write,
  input  logic [1:0] slow_op,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rs3,
  input  logic       rs3_valid,
  input  logic       flush,
  output logic       stall,
  output logic       slow_start,
  output logic [1:0] slow_op_out,
  output logic       slow_busy,
  output logic       wb_en,
  output logic       wb_sel,
  output logic [4:0] wb_rd
);

  slow_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       prd_q, prd_d;   // pending slow destination
  logic             pwr_q, pwr_d;   // pending slow op writes the regfile

  logic             hazard;
  logic             accept;
  logic             fast_push_vld;
  logic             tail_vld;
  logic [4:0]       tail_rd;

  fpu_fast_tracker #(
    .FAST_LAT (FAST_LAT)
  ) u_fast_tracker (
    .clk      (clk),
    .rstn     (rstn),
    .in_vld   (fast_push_vld),
    .in_rd    (rd),
    .tail_vld (tail_vld),
    .tail_rd  (tail_rd)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    prd_d      = prd_q;
    pwr_d      = pwr_q;
    stall      = 1'b0;
    slow_start = 1'b0;
    wb_en      = 1'b0;
    wb_sel     = 1'b0;
    wb_rd      = 5'd0;

    // RAW on any used source or WAW on rd against the outstanding slow op.
    hazard = pwr_q && (state_q != S_IDLE) &&
             ((rs1 == prd_q) || (rs2 == prd_q) ||
              (rs3_valid && (rs3 == prd_q)) || (rd == prd_q));

    // Fast ops are held off while the slow result waits in WB so the fast
    // pipe drains and the slow result gets the port within FAST_LAT cycles.
    if (id_valid && !flush) begin
      stall = (slow_fpu_dispatch && (state_q != S_IDLE)) ||
              (fast_fpu_dispatch && (state_q == S_WB)) ||
              hazard;
    end

    // Nothing issues while reset is asserted, keeping slow_start low.
    accept        = rstn && id_valid && !flush && !stall;
    fast_push_vld = accept && fast_fpu_dispatch && fpu_reg_write;

    if (tail_vld) begin
      wb_en  = 1'b1;
      wb_sel = 1'b0;
      wb_rd  = tail_rd;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept && slow_fpu_dispatch) begin
          slow_start = 1'b1;
          op_d       = slow_op;
          prd_d      = rd;
          pwr_d      = fpu_reg_write;
          cnt_d      = slow_cnt_init(slow_op, DIV_LAT, SQRT_LAT, FMA_LAT);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        // Moving to WB as the count reaches zero places the WB cycle exactly
        // <latency> cycles after slow_start.
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_WB;
      end
      S_WB: begin
        if (!tail_vld) begin
          wb_en   = pwr_q;
          wb_sel  = pwr_q;
          wb_rd   = pwr_q ? prd_q : 5'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 2'd0;
      prd_q   <= 5'd0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      prd_q   <= prd_d;
      pwr_q   <= pwr_d;
    end
  end

  assign slow_op_out = op_q;
  assign slow_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl
//   Directed bench for fpu_issue_ctrl. A cycle-level behavioural model
//   (slow op = "busy until ready cycle, then write when the port is free",
//   fast ops = list of due cycles) is compared against every output on every
//   cycle out of reset; literal expectations at fixed cycles pin the model.
module tb_fpu_issue_ctrl;

  localparam int FAST_LAT = 2;
  localparam int DIV_LAT  = 10;
  localparam int SQRT_LAT = 12;
  localparam int FMA_LAT  = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       id_valid, fast_fpu_dispatch, slow_fpu_dispatch, fpu_reg_write;
  logic [1:0] slow_op;
  logic [4:0] rd, rs1, rs2, rs3;
  logic       rs3_valid, flush;
  logic       stall, slow_start, slow_busy, wb_en, wb_sel;
  logic [1:0] slow_op_out;
  logic [4:0] wb_rd;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  fpu_issue_ctrl #(
    .FAST_LAT (FAST_LAT),
    .DIV_LAT  (DIV_LAT),
    .SQRT_LAT (SQRT_LAT),
    .FMA_LAT  (FMA_LAT)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .id_valid          (id_valid),
    .fast_fpu_dispatch (fast_fpu_dispatch),
    .slow_fpu_dispatch (slow_fpu_dispatch),
    .fpu_reg_write     (fpu_reg_write),
    .slow_op           (slow_op),
    .rd                (rd),
    .rs1               (rs1),
    .rs2               (rs2),
    .rs3               (rs3),
    .rs3_valid         (rs3_valid),
    .flush             (flush),
    .stall             (stall),
    .slow_start        (slow_start),
    .slow_op_out       (slow_op_out),
    .slow_busy         (slow_busy),
    .wb_en             (wb_en),
    .wb_sel            (wb_sel),
    .wb_rd             (wb_rd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model + compare ----------------
  bit         m_busy;
  int         m_ready;      // first cycle the slow result may be written
  logic [4:0] m_prd;
  bit         m_pwr;
  logic [1:0] m_op;
  int         fq_due[$];    // due cycles of writing fast ops, in order
  logic [4:0] fq_rd[$];

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b00:   return DIV_LAT;
      2'b01:   return SQRT_LAT;
      default: return FMA_LAT;
    endcase
  endfunction

  always @(negedge clk) begin : model_cmp
    bit         fast_hit, slow_elig, haz, e_stall, e_start, e_wen, e_sel, acc;
    logic [4:0] e_rd;
    if (!rstn) begin
      m_busy = 0; m_ready = 0; m_prd = 0; m_pwr = 0; m_op = 0;
      fq_due.delete(); fq_rd.delete();
    end else begin
      fast_hit  = (fq_due.size() > 0) && (fq_due[0] == cyc);
      slow_elig = m_busy && (cyc >= m_ready);
      haz = m_busy && m_pwr &&
            (rs1 == m_prd || rs2 == m_prd || (rs3_valid && rs3 == m_prd) || rd == m_prd);
      e_stall = id_valid && !flush &&
                ((slow_fpu_dispatch && m_busy) || (fast_fpu_dispatch && slow_elig) || haz);
      acc     = id_valid && !flush && !e_stall;
      e_start = acc && slow_fpu_dispatch && !m_busy;
      if (fast_hit) begin
        e_wen = 1; e_sel = 0; e_rd = fq_rd[0];
      end else if (slow_elig) begin
        e_wen = m_pwr; e_sel = m_pwr; e_rd = m_pwr ? m_prd : 5'd0;
      end else begin
        e_wen = 0; e_sel = 0; e_rd = 0;
      end

      chk("m_stall",       stall,       e_stall);
      chk("m_slow_start",  slow_start,  e_start);
      chk("m_slow_busy",   slow_busy,   m_busy);
      chk("m_slow_op_out", slow_op_out, m_op);
      chk("m_wb_en",       wb_en,       e_wen);
      chk("m_wb_sel",      wb_sel,      e_sel);
      chk("m_wb_rd",       wb_rd,       e_rd);

      if (slow_elig && !fast_hit) m_busy = 0;
      if (e_start) begin
        m_busy = 1; m_ready = cyc + lat_of(slow_op);
        m_prd = rd; m_pwr = fpu_reg_write; m_op = slow_op;
      end
      if (acc && fast_fpu_dispatch && fpu_reg_write) begin
        fq_due.push_back(cyc + FAST_LAT);
        fq_rd.push_back(rd);
      end
      while (fq_due.size() > 0 && fq_due[0] <= cyc) begin
        void'(fq_due.pop_front());
        void'(fq_rd.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) next();
  endtask

  task automatic drv_idle();
    id_valid = 0; fast_fpu_dispatch = 0; slow_fpu_dispatch = 0; fpu_reg_write = 0;
    slow_op = 0; rd = 0; rs1 = 0; rs2 = 0; rs3 = 0; rs3_valid = 0; flush = 0;
  endtask

  task automatic drv_slow(input logic [1:0] op, input logic [4:0] d, input logic w);
    drv_idle();
    id_valid = 1; slow_fpu_dispatch = 1; slow_op = op; rd = d; fpu_reg_write = w;
  endtask

  task automatic drv_fast(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic w);
    drv_idle();
    id_valid = 1; fast_fpu_dispatch = 1; rd = d; rs1 = s1; rs2 = s2; fpu_reg_write = w;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t0;
    int t_drop;
    rstn = 0;
    drv_idle();
    repeat (3) next();
    @(negedge clk);
    chk("rst_wb_en",     wb_en,       0);
    chk("rst_slow_busy", slow_busy,   0);
    chk("rst_op_out",    slow_op_out, 0);
    chk("rst_stall",     stall,       0);
    next();
    rstn = 1;
    repeat (2) next();

    // fdiv rd 3: start at 0, slow write at 10, idle at 11
    t0 = cyc; drv_slow(2'b00, 5'd3, 1);
    @(negedge clk); chk("div_start", slow_start, 1); chk("div_stall", stall, 0);
    next(); drv_idle();
    wait_to(t0 + 10); @(negedge clk);
    chk("div_wb_en", wb_en, 1); chk("div_wb_sel", wb_sel, 1); chk("div_wb_rd", wb_rd, 3);
    next(); @(negedge clk);
    chk("div_busy_clr", slow_busy, 0); chk("div_wb_off", wb_en, 0);
    next();

    // fast fadd rd 5: write at 2
    t0 = cyc; drv_fast(5'd5, 5'd1, 5'd2, 1);
    next(); drv_idle();
    wait_to(t0 + 2); @(negedge clk);
    chk("fadd_wb_en", wb_en, 1); chk("fadd_wb_sel", wb_sel, 0); chk("fadd_wb_rd", wb_rd, 5);
    chk("fadd_busy", slow_busy, 0);
    next();

    // fma rd 7 at 0, fast rd 8 at 2: fast wins at 4, slow writes at 5
    t0 = cyc; drv_slow(2'b10, 5'd7, 1);
    next(); drv_idle();
    wait_to(t0 + 2); drv_fast(5'd8, 5'd1, 5'd2, 1);
    @(negedge clk); chk("fma_fast_stall", stall, 0);
    next(); drv_idle();
    wait_to(t0 + 4); @(negedge clk);
    chk("fma_c4_rd", wb_rd, 8); chk("fma_c4_sel", wb_sel, 0); chk("fma_c4_busy", slow_busy, 1);
    next(); @(negedge clk);
    chk("fma_c5_en", wb_en, 1); chk("fma_c5_sel", wb_sel, 1); chk("fma_c5_rd", wb_rd, 7);
    next(); @(negedge clk); chk("fma_c6_busy", slow_busy, 0);
    next();

    // fast and slow dispatch are held off in WB, accepted the cycle after
    t0 = cyc; drv_slow(2'b10, 5'd7, 1);
    next(); drv_idle();
    wait_to(t0 + 4); drv_fast(5'd8, 5'd1, 5'd2, 1);
    @(negedge clk); chk("wb_fast_stall", stall, 1); chk("wb_fast_rd", wb_rd, 7);
    next(); @(negedge clk); chk("wb_fast_go", stall, 0);
    next(); drv_idle();
    t0 = cyc; drv_slow(2'b10, 5'd7, 1);
    next(); drv_idle();
    wait_to(t0 + 4); drv_slow(2'b00, 5'd20, 1);
    @(negedge clk); chk("wb_slow_stall", stall, 1); chk("wb_slow_nostart", slow_start, 0);
    next(); @(negedge clk); chk("wb_slow_start", slow_start, 1); chk("wb_slow_go", stall, 0);
    next(); drv_idle();
    wait_to(t0 + 5 + DIV_LAT + 1);

    // fsqrt rd 9 with dependent fadd (rs2 = 9): released the cycle after wb
    t0 = cyc; drv_slow(2'b01, 5'd9, 1);
    next(); drv_fast(5'd10, 5'd1, 5'd9, 1);
    t_drop = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall) begin
        t_drop = cyc;
        break;
      end
      next();
    end
    chk("raw_release", t_drop, t0 + 13);
    next(); drv_idle();
    wait_to(t0 + 16);

    // fsqrt rd 9 with independent fadd: no stall
    t0 = cyc; drv_slow(2'b01, 5'd9, 1);
    next(); drv_fast(5'd11, 5'd1, 5'd2, 1);
    @(negedge clk); chk("nodep_stall", stall, 0);
    next(); drv_idle();
    wait_to(t0 + 14);

    // rs3 only counts with rs3_valid; WAW on rd stalls
    t0 = cyc; drv_slow(2'b00, 5'd12, 1);
    next(); drv_fast(5'd13, 5'd1, 5'd2, 1); rs3 = 5'd12;
    @(negedge clk); chk("rs3_unused", stall, 0);
    next(); drv_fast(5'd14, 5'd1, 5'd2, 1); rs3 = 5'd12; rs3_valid = 1;
    @(negedge clk); chk("rs3_raw", stall, 1);
    next(); drv_fast(5'd12, 5'd1, 5'd2, 1);
    @(negedge clk); chk("waw", stall, 1);
    next(); drv_idle();
    wait_to(t0 + 12);

    // second fdiv while BUSY stalls; flush drops stall and start
    t0 = cyc; drv_slow(2'b00, 5'd4, 1);
    next(); drv_slow(2'b00, 5'd6, 1);
    @(negedge clk); chk("busy2_stall", stall, 1); chk("busy2_start", slow_start, 0);
    next(); flush = 1;
    @(negedge clk); chk("flush_stall", stall, 0); chk("flush_start", slow_start, 0);
    next(); drv_idle();
    wait_to(t0 + 12);

    // slow_op 11 runs with FMA latency
    t0 = cyc; drv_slow(2'b11, 5'd15, 1);
    next(); drv_idle();
    @(negedge clk); chk("op11_out", slow_op_out, 3);
    wait_to(t0 + 4); @(negedge clk);
    chk("op11_wb_en", wb_en, 1); chk("op11_wb_rd", wb_rd, 15);
    next();

    // non-writing slow and fast ops produce no write
    t0 = cyc; drv_slow(2'b00, 5'd16, 0);
    next(); drv_idle();
    wait_to(t0 + 10); @(negedge clk);
    chk("nowr_slow_en", wb_en, 0); chk("nowr_slow_rd", wb_rd, 0); chk("nowr_slow_busy", slow_busy, 1);
    next(); @(negedge clk); chk("nowr_slow_idle", slow_busy, 0);
    next();
    t0 = cyc; drv_fast(5'd17, 5'd1, 5'd2, 0);
    next(); drv_idle();
    wait_to(t0 + 2); @(negedge clk); chk("nowr_fast_en", wb_en, 0);
    next();

    // reset while in WB discards the result; slow dispatch accepted after
    t0 = cyc; drv_slow(2'b00, 5'd3, 1);
    next(); drv_idle();
    wait_to(t0 + 10); rstn = 0;
    next(); rstn = 1; drv_slow(2'b00, 5'd3, 1);
    @(negedge clk);
    chk("rstwb_en", wb_en, 0); chk("rstwb_busy", slow_busy, 0); chk("rstwb_start", slow_start, 1);
    next(); drv_idle();
    wait_to(t0 + 11 + DIV_LAT + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameters SHALL be: FAST_LAT, default 2, fast-FPU fixed latency in cycles; DIV_LAT 10, fdiv latency; SQRT_LAT 12, fsqrt latency; FMA_LAT 4, fmadd/fmsub/fnmsub/fnmadd latency.
REQ-002 Ports SHALL be, as name direction width meaning:
- clk in 1 clock
- rstn in 1 synchronous active-low reset
- id_valid in 1 decode-stage FPU instruction present
- fast_fpu_dispatch in 1 op targets fast FPU
- slow_fpu_dispatch in 1 op targets slow FPU
- fpu_reg_write in 1 op writes FPU regfile
- slow_op in 2 slow op class: 00 div, 01 sqrt, 10 fma
- rd in 5 destination FPU register
- rs1/rs2/rs3 in 5 each, FPU sources
- rs3_valid in 1 rs3 used (r4 op)
- flush in 1 kill current decode op
- stall out 1 hold decode stage
- slow_start out 1 one-cycle start pulse to slow FPU
- slow_op_out out 2 registered slow op class
- slow_busy out 1 slow FPU occupied
- wb_en out 1 FPU regfile write enable
- wb_sel out 1 0 = fast result, 1 = slow result
- wb_rd out 5 FPU regfile write address

Function
REQ-003 Accept SHALL be id_valid & ~stall & ~flush; with ~id_valid or flush, stall SHALL be 0 and nothing SHALL issue.
REQ-004 Slow FSM SHALL have states IDLE, BUSY and WB; slow_busy SHALL be 1 in BUSY and WB.
REQ-005 IDLE->BUSY on accepted slow dispatch: slow_start = 1 that cycle, latch slow_op_out, pending rd and write flag, load counter with latency-1 per slow_op.
REQ-006 slow_op 11 SHALL be treated as FMA_LAT.
REQ-007 In BUSY the counter SHALL decrement each cycle; on counter 0 it SHALL go to WB (the result is held by the slow unit).
REQ-008 In WB: if no fast writeback that cycle, assert wb_en = pending write flag, wb_sel = 1, wb_rd = pending rd, go to IDLE; otherwise remain in WB.
REQ-009 Fast tracking SHALL be a FAST_LAT-deep shift register of {valid, rd}; accepted fast dispatch with fpu_reg_write SHALL enter valid = 1.
REQ-010 The tail entry SHALL produce wb_en = 1, wb_sel = 0, wb_rd = entry rd; fast SHALL always win the port.
REQ-011 stall SHALL be 1 when any of:
- slow dispatch while FSM ≠ IDLE
- fast dispatch while FSM = WB (anti-starvation; the fast pipe drains within FAST_LAT cycles)
- any of rs1, rs2, or rs3 (if rs3_valid) equals pending slow rd while FSM ≠ IDLE and write flag set
- rd equals pending slow rd under the same condition (WAW)
REQ-012 Slow-write and IDLE-dispatch in the same cycle: WB->IDLE SHALL NOT accept a new slow dispatch that cycle (stall from WB state).
REQ-013 wb_en SHALL be at most one write per cycle; when no write occurs, wb_sel and wb_rd SHALL be 0.
REQ-014 Fast ops with fpu_reg_write = 0 (e.g. feq to integer) SHALL occupy the shift register with valid = 0.

Reset
REQ-015 On clk edge with rstn = 0, the FSM SHALL be IDLE, counter 0, all shift entries invalid, pending rd 0, and all outputs 0, including mid-BUSY/WB (the result is discarded).

Structure
REQ-016 A shared FPU package SHALL hold: the slow_op encoding enum, the FSM state enum, and the latency constants.
REQ-017 The fast tracking shift register SHALL be sub-module fpu_fast_tracker (parameter FAST_LAT).
REQ-018 The design SHALL be one always_ff for state and one always_comb for stall and writeback mux.

Verification
REQ-019 fdiv rd = 3 accepted at cycle 0 -> slow_start at cycle 0; wb_en, wb_sel = 1, wb_rd = 3 at cycle 10; slow_busy is 0 at cycle 11.
REQ-020 Fast fadd rd = 5 accepted at cycle 0 -> wb_en, wb_sel = 0, wb_rd = 5 at cycle 2; slow_busy stays 0.
REQ-021 fma rd = 7 at cycle 0, fast rd = 8 at cycle 2 -> fast writes rd 8 at cycle 4, FSM stays WB, slow writes rd 7 at cycle 5.
REQ-022 fsqrt rd = 9 in BUSY, decode fadd with rs2 = 9 -> stall = 1 until the cycle after rd 9 writeback; fadd with no dependence -> no stall.
REQ-023 Second fdiv while BUSY -> stall = 1; flush with id_valid -> stall = 0 and slow_start = 0.
REQ-024 rstn = 0 in WB -> next cycle wb_en = 0, slow_busy = 0, and new slow dispatch accepted after rstn = 1.
